// File: rtl/gate_arb_pkg.sv
// Shared types and constants for the gate_op_arbiter block: opcodes,
// FSM state encoding and a 2:1 mux primitive used to build the gates.
package gate_arb_pkg;

   typedef logic [2:0] opcode_t;

   localparam opcode_t OP_AND  = 3'd0;
   localparam opcode_t OP_NAND = 3'd1;
   localparam opcode_t OP_OR   = 3'd2;
   localparam opcode_t OP_NOR  = 3'd3;
   localparam opcode_t OP_NOT  = 3'd4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   function automatic logic mux2(input logic sel, input logic in0, input logic in1);
      return sel ? in1 : in0;
   endfunction

endpackage

// File: rtl/gate_unit_mux.sv
// Combinational gate unit: every gate and the opcode selector are built
// purely from 2:1 muxes. Opcodes above OP_NOT flag illegal and yield 0.
module gate_unit_mux
   import gate_arb_pkg::*;
(
   input  opcode_t op,
   input  logic    x,
   input  logic    y,
   output logic    result,
   output logic    illegal
);

   logic [7:0] gate;
   logic [3:0] lvl1;
   logic [1:0] lvl2;

   // x acts as the select line; y (or its inverse) or a constant is the data
   assign gate[OP_AND]  = mux2(x, 1'b0, y);
   assign gate[OP_NAND] = mux2(x, 1'b1, ~y);
   assign gate[OP_OR]   = mux2(x, y, 1'b1);
   assign gate[OP_NOR]  = mux2(x, ~y, 1'b0);
   assign gate[OP_NOT]  = mux2(x, 1'b1, 1'b0);
   assign gate[7:5]     = 3'b000;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lvl1
         assign lvl1[gi] = mux2(op[0], gate[2*gi], gate[2*gi+1]);
      end
      for (gi = 0; gi < 2; gi++) begin : g_lvl2
         assign lvl2[gi] = mux2(op[1], lvl1[2*gi], lvl1[2*gi+1]);
      end
   endgenerate

   assign result  = mux2(op[2], lvl2[0], lvl2[1]);
   assign illegal = (op > OP_NOT);

endmodule

// File: rtl/gate_op_arbiter.sv
// Round-robin arbiter sharing one gate_unit_mux among NREQ requesters.
// Optional macro GATE_ARB_ERR_EN drives err for illegal opcodes.
module gate_op_arbiter
   import gate_arb_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int IDW  = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NREQ-1:0]      req,
   input  logic [3*NREQ-1:0]    op,
   input  logic [NREQ-1:0]      x,
   input  logic [NREQ-1:0]      y,
   output logic [NREQ-1:0]      gnt,
   output logic [NREQ-1:0]      ack,
   output logic                 res_valid,
   input  logic                 res_ready,
   output logic                 res_data,
   output logic [IDW-1:0]       res_id,
   output logic                 err
);

   state_t          state_reg, state_next;
   logic [IDW-1:0]  rr_ptr_reg, rr_ptr_next;
   logic [IDW-1:0]  idx_reg, idx_next;
   opcode_t         op_reg, op_next;
   logic            x_reg, x_next;
   logic            y_reg, y_next;
   logic [NREQ-1:0] ack_reg, ack_next;
   logic            res_valid_reg, res_valid_next;
   logic            res_data_reg, res_data_next;
   logic [IDW-1:0]  res_id_reg, res_id_next;
   logic            err_reg, err_next;

   logic [NREQ-1:0] hi_mask;
   logic [NREQ-1:0] req_hi;
   logic [IDW-1:0]  sel_idx;
   opcode_t         sel_op;
   logic            sel_x;
   logic            sel_y;
   logic            gate_result;
   logic            gate_illegal;

   // Requesters at or above rr_ptr win first; otherwise wrap to the lowest.
   genvar gi;
   generate
      for (gi = 0; gi < NREQ; gi++) begin : g_sel
         assign hi_mask[gi] = (IDW'(gi) >= rr_ptr_reg);
         assign gnt[gi]     = (state_reg == EXEC) && (idx_reg == IDW'(gi));
      end
   endgenerate

   assign req_hi = req & hi_mask;

   always_comb begin
      sel_idx = '0;
      if (|req_hi) begin
         for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_hi[i]) sel_idx = IDW'(i);
         end
      end else begin
         for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[i]) sel_idx = IDW'(i);
         end
      end
   end

   always_comb begin
      sel_op = OP_AND;
      sel_x  = 1'b0;
      sel_y  = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         if (sel_idx == IDW'(i)) begin
            sel_op = op[3*i +: 3];
            sel_x  = x[i];
            sel_y  = y[i];
         end
      end
   end

   gate_unit_mux u_gate (
      .op      (op_reg),
      .x       (x_reg),
      .y       (y_reg),
      .result  (gate_result),
      .illegal (gate_illegal)
   );

   always_comb begin
      state_next     = state_reg;
      rr_ptr_next    = rr_ptr_reg;
      idx_next       = idx_reg;
      op_next        = op_reg;
      x_next         = x_reg;
      y_next         = y_reg;
      ack_next       = '0;
      res_valid_next = res_valid_reg;
      res_data_next  = res_data_reg;
      res_id_next    = res_id_reg;
      err_next       = err_reg;

      case (state_reg)
         IDLE: begin
            if (|req) begin
               idx_next   = sel_idx;
               op_next    = sel_op;
               x_next     = sel_x;
               y_next     = sel_y;
               state_next = EXEC;
            end
         end
         EXEC: begin
            res_data_next  = gate_result & ~gate_illegal;
            res_id_next    = idx_reg;
`ifdef GATE_ARB_ERR_EN
            err_next       = gate_illegal;
`else
            err_next       = 1'b0;
`endif
            res_valid_next = 1'b1;
            ack_next       = gnt;
            state_next     = RESP;
         end
         RESP: begin
            if (res_ready) begin
               res_valid_next = 1'b0;
               rr_ptr_next    = (idx_reg == IDW'(NREQ - 1)) ? '0 : idx_reg + IDW'(1);
               state_next     = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= IDLE;
         rr_ptr_reg    <= '0;
         idx_reg       <= '0;
         op_reg        <= OP_AND;
         x_reg         <= 1'b0;
         y_reg         <= 1'b0;
         ack_reg       <= '0;
         res_valid_reg <= 1'b0;
         res_data_reg  <= 1'b0;
         res_id_reg    <= '0;
         err_reg       <= 1'b0;
      end else begin
         state_reg     <= state_next;
         rr_ptr_reg    <= rr_ptr_next;
         idx_reg       <= idx_next;
         op_reg        <= op_next;
         x_reg         <= x_next;
         y_reg         <= y_next;
         ack_reg       <= ack_next;
         res_valid_reg <= res_valid_next;
         res_data_reg  <= res_data_next;
         res_id_reg    <= res_id_next;
         err_reg       <= err_next;
      end
   end

   assign ack       = ack_reg;
   assign res_valid = res_valid_reg;
   assign res_data  = res_data_reg;
   assign res_id    = res_id_reg;
   assign err       = err_reg;

endmodule

// File: doc/gate_op_arbiter.md
# gate_op_arbiter

Round-robin arbiter and sequencer that shares one mux-based logic-gate unit among NREQ requesters. Each requester presents an opcode and two 1-bit operands. The arbiter grants one requester at a time, latches its operands, and evaluates them through the shared gate unit. It then returns the registered result with the requester ID over a valid/ready handshake. It sits between per-channel control logic and the single gate-evaluation resource.

## Interface
- NREQ, 4, number of requesters (2..8)
- IDW, 2, width of requester ID; must satisfy 2^IDW >= NREQ
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req  in  NREQ  per-requester request, level, held until ack
- op  in  3*NREQ  opcode of requester i at op[3i+2:3i]
- x  in  NREQ  operand x of requester i
- y  in  NREQ  operand y of requester i
- gnt  out  NREQ  one-hot grant, high during EXEC
- ack  out  NREQ  one-cycle pulse: operands of requester i consumed
- res_valid  out  1  result valid
- res_ready  in  1  downstream accepts result
- res_data  out  1  gate result
- res_id  out  IDW  index of the requester that produced res_data
- err  out  1  illegal opcode flag, qualified by res_valid

## Operation
- Opcodes:
  - 0 AND x&y
  - 1 NAND ~(x&y)
  - 2 OR x|y
  - 3 NOR ~(x|y)
  - 4 NOT ~x (y ignored)
  - 5..7 illegal
- FSM states IDLE, EXEC, RESP.
- IDLE: when any req bit is high, select the first set bit searching from rr_ptr upward with wrap-around. Latch op, x and y of the selected requester and its index, then go to EXEC. With no req, stay in IDLE.
- EXEC (one cycle): gnt is one-hot at the latched index. The shared gate unit evaluates the latched operands. At the clock edge, register res_data, res_id and err, set res_valid, pulse ack[index], and go to RESP.
- RESP: hold res_valid, res_data, res_id and err stable until res_valid&res_ready. On that edge:
  - clear res_valid
  - set rr_ptr = (index+1) mod NREQ
  - go to IDLE
- ack is high during the first RESP cycle only.
- Arbitration happens only in IDLE. A req still high after its ack is treated as a new request and competes normally.
- A req dropped before it is selected is never served.
- A req dropped during EXEC or RESP has no effect, because its operands are already latched.
- Illegal opcode: res_data = 0; err follows the Configuration section.
- Reset at any time, including mid-transaction:
  - state goes to IDLE, rr_ptr = 0
  - gnt, ack, res_valid, res_data, res_id and err all go to 0
  - the in-flight transaction is discarded with no ack
  - requesters must re-present their requests

## Timing
- Request sampled in IDLE at edge 0. gnt is high during cycle 1 (EXEC). res_valid and ack are high from cycle 2.
- If res_ready is high in cycle 2, the FSM is back in IDLE in cycle 3. The fastest back-to-back service is one result per 3 cycles.
- res_ready held low: the FSM stays in RESP indefinitely with stable outputs and no new grants.
- res_ready may be asserted before res_valid; it only takes effect while in RESP.
- All outputs are registered except gnt, which is decoded from the registered state and index (glitch-free, no input-to-output path).

## Configuration
- GATE_ARB_ERR_EN defined: err = 1 alongside res_valid for opcodes 5..7, otherwise 0.
- GATE_ARB_ERR_EN undefined: err is tied to 0. Illegal opcodes still give res_data = 0 and complete a normal transaction.

## Structure
- Package gate_arb_pkg holds:
  - opcode localparams OP_AND..OP_NOT
  - the state enum (IDLE, EXEC, RESP)
  - the 3-bit opcode type
- Sub-module gate_unit_mux: combinational, inputs op/x/y, outputs result and illegal. Each gate is built from 2x1 muxes and the opcode selects the output. It is instantiated once, driven only by the latched operands.
- Top level contains the FSM, the round-robin pointer/selector and the output registers.

## Test plan
- Reset: rst_n low mid-RESP with res_valid=1 -> all outputs go to 0 immediately. After release, the first grant goes to the lowest requesting index.
- Single op sweep: requester 2 with x=1, y=0 and op 0..4 -> res_data 0,1,1,0,0, res_id=2. Each result is valid 2 cycles after req; ack[2] pulses once per op.
- Round-robin: req=4'b1111 held, res_ready=1 -> res_id sequence 0,1,2,3,0. No requester is starved; gnt is always one-hot.
- Backpressure: res_ready=0 for 5 cycles while req[1] is pending -> res_valid and res_data stay stable and gnt stays 0. Asserting res_ready moves the FSM to IDLE, then requester 1 is granted.
- Illegal op: op=6 -> res_data=0. err=1 with GATE_ARB_ERR_EN, err=0 without it.
- Late drop: req[3] deasserted during EXEC -> the result is still delivered with res_id=3.
